fifo_rd_stream: RTL and testbench

- Read-side controller for the team's synchronous BRAM FIFO.
- Issues pops to the FIFO and tracks the fixed read latency of in-flight pops.
- Captures returned words into a small skid buffer and presents them as a valid/ready stream to the consumer.
- Sustains one word per cycle under continuous m_ready_i, with no combinational path from m_ready_i to fifo_pop_o other than the credit term.

---
 rtl/fifo_rd_stream_if.sv | 38 +++
 rtl/fifo_rd_stream.sv | 122 ++++++++++++
 tb/tb_fifo_rd_stream.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : fifo_rd_stream_if                                           |
// | Purpose  : Bundles the FIFO read-port signals and the outgoing          |
// |            valid/ready stream of the fifo_rd_stream controller.        |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
);
  localparam int BUF_DEPTH = READ_LATENCY + 1;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

  logic                  flush_i;
  logic                  fifo_empty_i;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  fifo_rderr_i;
  logic                  fifo_pop_o;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic [OCC_W-1:0]      occupancy_o;
  logic                  err_o;

  // Controller side: consumes FIFO flags/data and consumer ready.
  modport master (
    input  flush_i, fifo_empty_i, fifo_data_i, fifo_rderr_i, m_ready_i,
    output fifo_pop_o, m_valid_o, m_data_o, occupancy_o, err_o
  );

  // Environment side: the FIFO plus the stream consumer.
  modport slave (
    output flush_i, fifo_empty_i, fifo_data_i, fifo_rderr_i, m_ready_i,
    input  fifo_pop_o, m_valid_o, m_data_o, occupancy_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : fifo_rd_stream                                              |
// | Purpose  : Pops a fixed-latency BRAM FIFO, tracks in-flight reads,     |
// |            captures returning words into a skid buffer and presents    |
// |            them as a valid/ready stream at one word per cycle.         |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module fifo_rd_stream #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  fifo_rd_stream_if.master        bus
);
  // Enough slots to absorb every pop that can be in flight when the
  // consumer stalls, so popping never has to look at m_ready_i directly.
  localparam int BUF_DEPTH = READ_LATENCY + 1;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam int ARITH_W   = CNT_W + 1;
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  logic [READ_LATENCY-1:0] pipe_v;
  logic [DATA_WIDTH-1:0]   mem [0:BUF_DEPTH-1];
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [CNT_W-1:0]        buf_count;
  logic                    err;
  logic [CNT_W-1:0]        inflight;
  logic [ARITH_W-1:0]      demand;
  logic                    valid;
  logic                    deq;
  logic                    capture;
  logic                    pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid   = (buf_count != '0);
  assign deq     = valid & bus.m_ready_i;
  assign capture = pipe_v[READ_LATENCY-1] & ~bus.flush_i;

  // Count outstanding pops still travelling through the FIFO read pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CNT_W'(pipe_v[i]);
    end
  end

  // Slots claimed after this cycle's dequeue; one extra bit keeps the
  // subtraction from wrapping.
  assign demand = ARITH_W'(inflight) + ARITH_W'(buf_count) - ARITH_W'(deq);
  assign pop    = ~bus.fifo_empty_i & ~bus.flush_i & ~rst_i &
                  (demand < ARITH_W'(BUF_DEPTH));

  // Shift the pop markers along so the last stage flags returning data.
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= pop;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
      end
    end
  end

  // Skid buffer: capture at the tail, dequeue from the head.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head      <= '0;
      tail      <= '0;
      buf_count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.flush_i) begin
      head      <= '0;
      tail      <= '0;
      buf_count <= '0;
    end else begin
      if (capture) begin
        mem[tail] <= bus.fifo_data_i;
        tail      <= next_ptr(tail);
      end
      if (deq) begin
        head <= next_ptr(head);
      end
      case ({capture, deq})
        2'b10:   buf_count <= buf_count + CNT_W'(1);
        2'b01:   buf_count <= buf_count - CNT_W'(1);
        default: buf_count <= buf_count;
      endcase
    end
  end

  // Sticky read-error flag; reset and flush both clear it.
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      err <= 1'b0;
    end else if (bus.fifo_rderr_i) begin
      err <= 1'b1;
    end
  end

  assign bus.fifo_pop_o  = pop;
  assign bus.m_valid_o   = valid;
  assign bus.m_data_o    = mem[head];
  assign bus.occupancy_o = inflight + buf_count;
  assign bus.err_o       = err;

  // The pop rule must keep a capture from ever landing in a full buffer.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(capture && (buf_count == CNT_W'(BUF_DEPTH)) && !deq));

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_fifo_rd_stream                                           |
// | Purpose  : Drives two fifo_rd_stream instances (latency 1 and 2) from  |
// |            a shared FIFO word source and compares them cycle by cycle  |
// |            against a queue-based reference model.                      |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_fifo_rd_stream;
  logic        clk;
  logic        rst;
  logic        flush;
  logic        rdy;
  logic        rderr;
  logic        gate;
  logic        chk_en;
  logic [31:0] src [0:1023];
  int          loaded;
  int          n_tests;
  int          n_fail;

  logic [1:0]        pop_w;
  logic [1:0]        valid_w;
  logic [1:0]        err_w;
  logic [1:0][31:0]  data_w;
  logic [1:0][3:0]   occ_w;
  logic [1:0][15:0]  dcnt_w;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int RL = g + 1;
    localparam int BD = RL + 1;

    fifo_rd_stream_if #(.DATA_WIDTH(32), .READ_LATENCY(RL)) bus ();

    logic [31:0] fdata;
    logic        fempty;
    logic [15:0] dcnt;
    int          cyc;
    int          popped;
    int          mpop;
    logic [31:0] do_w[$];
    int          do_t[$];
    logic [31:0] buf_q[$];
    logic [31:0] pend_w[$];
    int          pend_t[$];
    logic        exp_err;
    logic        m_ev, m_deq, m_pop;
    int          m_occ;
    logic        s_pop, s_mpop, s_mdeq, s_flush, s_rst, s_rderr;

    assign bus.flush_i      = flush;
    assign bus.fifo_empty_i = fempty;
    assign bus.fifo_data_i  = fdata;
    assign bus.fifo_rderr_i = rderr;
    assign bus.m_ready_i    = rdy;

    fifo_rd_stream #(.DATA_WIDTH(32), .READ_LATENCY(RL)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.master)
    );

    assign pop_w[g]   = bus.fifo_pop_o;
    assign valid_w[g] = bus.m_valid_o;
    assign err_w[g]   = bus.err_o;
    assign data_w[g]  = bus.m_data_o;
    assign occ_w[g]   = 4'(bus.occupancy_o);
    assign dcnt_w[g]  = dcnt;

    initial begin
      fdata = '0; fempty = 1'b1; dcnt = '0; cyc = 0; popped = 0; mpop = 0;
      exp_err = 1'b0;
      s_pop = 0; s_mpop = 0; s_mdeq = 0; s_flush = 0; s_rst = 1; s_rderr = 0;
    end

    // Mid-cycle: predict this cycle's outputs and compare, then snapshot.
    always @(negedge clk) begin
      m_ev  = (buf_q.size() != 0);
      m_occ = pend_w.size() + buf_q.size();
      m_deq = m_ev && rdy;
      m_pop = !fempty && !flush && !rst && ((m_occ - (m_deq ? 1 : 0)) < BD);
      if (chk_en) begin
        chk($sformatf("L%0d pop", RL), 32'(bus.fifo_pop_o), 32'(m_pop));
        chk($sformatf("L%0d valid", RL), 32'(bus.m_valid_o), 32'(m_ev));
        if (m_ev) chk($sformatf("L%0d data", RL), bus.m_data_o, buf_q[0]);
        chk($sformatf("L%0d occupancy", RL), 32'(bus.occupancy_o), 32'(m_occ));
        chk($sformatf("L%0d occ_bound", RL), 32'(bus.occupancy_o <= BD), 32'd1);
        chk($sformatf("L%0d err", RL), 32'(bus.err_o), 32'(exp_err));
      end
      s_pop = bus.fifo_pop_o; s_mpop = m_pop; s_mdeq = m_deq;
      s_flush = flush; s_rst = rst; s_rderr = rderr;
      if (bus.m_valid_o && rdy) dcnt = dcnt + 16'd1;
    end

    // After each edge: advance the reference model and the FIFO model.
    always @(posedge clk) begin
      #2;
      if (s_rst || s_flush) begin
        buf_q.delete(); pend_w.delete(); pend_t.delete();
        mpop = loaded;
      end else begin
        if (s_mdeq) void'(buf_q.pop_front());
        if (s_mpop) begin
          pend_w.push_back(src[mpop]);
          pend_t.push_back(cyc + RL + 1);
          mpop++;
        end
      end
      if (s_rst || s_flush) exp_err = 1'b0;
      else if (s_rderr)     exp_err = 1'b1;
      if (s_pop && popped < loaded) begin
        do_w.push_back(src[popped]);
        do_t.push_back(cyc + RL);
        popped++;
      end
      if (s_rst || s_flush) popped = loaded;
      cyc++;
      while (pend_t.size() != 0 && pend_t[0] <= cyc) begin
        buf_q.push_back(pend_w.pop_front());
        void'(pend_t.pop_front());
      end
      while (do_t.size() != 0 && do_t[0] < cyc) begin
        void'(do_w.pop_front()); void'(do_t.pop_front());
      end
      fdata = $urandom();
      if (do_t.size() != 0 && do_t[0] == cyc) begin
        fdata = do_w.pop_front();
        void'(do_t.pop_front());
      end
      fempty = (popped >= loaded) || gate;
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic nstep(input int n);
    repeat (n) step();
  endtask

  task automatic at_neg;
    @(negedge clk); #1;
  endtask

  task automatic load(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) src[loaded + i] = base + 32'(i);
    loaded += n;
  endtask

  int fp[2], lp[2], np[2], fv[2], lv[2], nv[2], bad[2];
  logic [31:0] fd[2], ld[2];
  logic [15:0] b0[2];
  int cnt;

  task automatic clr_stats;
    for (int g = 0; g < 2; g++) begin
      fp[g] = -1; lp[g] = -1; np[g] = 0; fv[g] = -1; lv[g] = -1; nv[g] = 0; bad[g] = 0;
    end
  endtask

  task automatic sample(input int c);
    for (int g = 0; g < 2; g++) begin
      if (pop_w[g]) begin
        if (fp[g] < 0) fp[g] = c;
        lp[g] = c; np[g]++;
      end
      if (valid_w[g]) begin
        if (fv[g] < 0) begin fv[g] = c; fd[g] = data_w[g]; end
        lv[g] = c; nv[g]++; ld[g] = data_w[g];
      end
    end
  endtask

  initial begin
    clk = 0; rst = 1; flush = 0; rdy = 0; rderr = 0; gate = 0;
    loaded = 0; chk_en = 0; n_tests = 0; n_fail = 0;
    nstep(3);
    chk_en = 1; rst = 0;
    at_neg();
    chk("reset pop", 32'(pop_w), 32'd0);
    chk("reset valid", 32'(valid_w), 32'd0);
    chk("reset data0", data_w[0], 32'd0);
    chk("reset data1", data_w[1], 32'd0);
    chk("reset occ", 32'({occ_w[1], occ_w[0]}), 32'd0);
    chk("reset err", 32'(err_w), 32'd0);

    // Single word.
    rdy = 1;
    step(); load(1, 32'hA5A5_0001);
    at_neg(); chk("single pop c0", 32'(pop_w), 32'b11);
    step(); at_neg(); chk("single valid c1", 32'(valid_w), 32'b00);
    step(); at_neg(); chk("single valid c2", 32'(valid_w), 32'b01);
    chk("single data L1", data_w[0], 32'hA5A5_0001);
    step(); at_neg(); chk("single valid c3", 32'(valid_w), 32'b10);
    chk("single data L2", data_w[1], 32'hA5A5_0001);
    chk("single pop c3", 32'(pop_w), 32'b00);
    nstep(4);

    // Throughput: 16 words, ready always high.
    load(16, 32'd0);
    clr_stats();
    for (int c = 0; c < 40; c++) begin
      at_neg(); sample(c); step();
    end
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("thru L%0d pops", g + 1), 32'(np[g]), 32'd16);
      chk($sformatf("thru L%0d pop run", g + 1), 32'(lp[g] - fp[g]), 32'd15);
      chk($sformatf("thru L%0d valids", g + 1), 32'(nv[g]), 32'd16);
      chk($sformatf("thru L%0d valid run", g + 1), 32'(lv[g] - fv[g]), 32'd15);
      chk($sformatf("thru L%0d latency", g + 1), 32'(fv[g] - fp[g]), 32'(g + 2));
      chk($sformatf("thru L%0d first", g + 1), fd[g], 32'd0);
      chk($sformatf("thru L%0d last", g + 1), ld[g], 32'd15);
    end

    // Backpressure: 10 words, consumer stalled.
    rdy = 0; load(10, 32'd0);
    clr_stats();
    for (int c = 0; c < 12; c++) begin
      at_neg(); sample(c);
      for (int g = 0; g < 2; g++) if (valid_w[g] && data_w[g] != 32'd0) bad[g]++;
      step();
    end
    at_neg();
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("bp L%0d pops", g + 1), 32'(np[g]), 32'(g + 2));
      chk($sformatf("bp L%0d occ", g + 1), 32'(occ_w[g]), 32'(g + 2));
      chk($sformatf("bp L%0d valid", g + 1), 32'(valid_w[g]), 32'd1);
      chk($sformatf("bp L%0d data", g + 1), data_w[g], 32'd0);
      chk($sformatf("bp L%0d stable", g + 1), 32'(bad[g]), 32'd0);
    end
    step(); rdy = 1;
    clr_stats();
    for (int c = 0; c < 20; c++) begin
      at_neg(); sample(c); step();
    end
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("bp L%0d delivered", g + 1), 32'(nv[g]), 32'd10);
      chk($sformatf("bp L%0d no gaps", g + 1), 32'(lv[g] - fv[g]), 32'd9);
      chk($sformatf("bp L%0d last", g + 1), ld[g], 32'd9);
    end

    // Flush with pops in flight.
    rdy = 0; load(5, 32'h100);
    step();
    step(); flush = 1;
    at_neg(); chk("flush pop", 32'(pop_w), 32'd0);
    step(); flush = 0;
    at_neg();
    chk("flush valid", 32'(valid_w), 32'd0);
    chk("flush occ", 32'({occ_w[1], occ_w[0]}), 32'd0);
    clr_stats();
    for (int c = 0; c < 6; c++) begin
      step(); at_neg(); sample(c);
    end
    chk("flush no stale L1", 32'(nv[0]), 32'd0);
    chk("flush no stale L2", 32'(nv[1]), 32'd0);
    step();
    b0[0] = dcnt_w[0]; b0[1] = dcnt_w[1];
    rdy = 1; load(4, 32'h200);
    nstep(15);
    chk("refill L1", 32'(16'(dcnt_w[0] - b0[0])), 32'd4);
    chk("refill L2", 32'(16'(dcnt_w[1] - b0[1])), 32'd4);

    // Sticky error.
    rderr = 1; step(); rderr = 0;
    at_neg(); chk("err set", 32'(err_w), 32'b11);
    nstep(5);
    at_neg(); chk("err held", 32'(err_w), 32'b11);
    step();

    // Random ready and empty toggling, 200 words.
    b0[0] = dcnt_w[0]; b0[1] = dcnt_w[1];
    for (int i = 0; i < 200; i++) src[loaded + i] = $urandom();
    loaded += 200;
    cnt = 0;
    while (cnt < 3000 && (16'(dcnt_w[0] - b0[0]) < 16'd200 || 16'(dcnt_w[1] - b0[1]) < 16'd200)) begin
      rdy  = 1'($urandom_range(0, 1));
      gate = ($urandom_range(0, 4) == 0);
      step();
      cnt++;
    end
    rdy = 1; gate = 0;
    chk("random L1 count", 32'(16'(dcnt_w[0] - b0[0])), 32'd200);
    chk("random L2 count", 32'(16'(dcnt_w[1] - b0[1])), 32'd200);
    nstep(4);

    // Reset in the middle of a stream.
    load(20, 32'h300);
    nstep(6);
    rst = 1;
    at_neg(); chk("rst pop", 32'(pop_w), 32'd0);
    step(); rst = 0;
    at_neg();
    chk("rst valid", 32'(valid_w), 32'd0);
    chk("rst occ", 32'({occ_w[1], occ_w[0]}), 32'd0);
    chk("rst err", 32'(err_w), 32'd0);
    chk("rst data0", data_w[0], 32'd0);
    chk("rst data1", data_w[1], 32'd0);
    clr_stats();
    for (int c = 0; c < 8; c++) begin
      step(); at_neg(); sample(c);
    end
    chk("rst no stale", 32'(nv[0] + nv[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
